// File: rtl/mem_unit_pkg.sv
// Shared definitions for the memory stage: default widths and the writeback record layout.
package mem_unit_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 16;
    localparam int REG_W_DEF  = 3;
    localparam int CNT_W_DEF  = 16;

    // Writeback record at the default widths (destination register plus data).
    typedef struct packed {
        logic [REG_W_DEF-1:0]  dst_reg;
        logic [DATA_W_DEF-1:0] data;
    } wb_rec_t;

endpackage

// File: rtl/mem_unit_ram.sv
// Single-port synchronous RAM, DEPTH x DATA_W, with registered read-before-write data.
// Addresses at or beyond DEPTH wrap modulo DEPTH. Contents are never reset.
module mem_unit_ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int DEPTH  = (1 << ADDR_W)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;

    assign idx = IDX_W'(32'(addr) % 32'(DEPTH));

    // On an enabled access capture the old word, then optionally overwrite it.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[idx];
            if (we) begin
                mem[idx] <= wdata;
            end
        end
    end

endmodule

// File: rtl/mem_stage_unit.sv
// Pipelined memory stage between execute and register writeback.
// Accepts one request per cycle over valid/ready, accesses data memory and
// emits a registered writeback record one cycle after acceptance.
// Optional build macro MEM_STAGE_STATS_EN adds saturating load/store counters.
module mem_stage_unit
    import mem_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int DEPTH  = (1 << ADDR_W)
`ifdef MEM_STAGE_STATS_EN
    ,
    parameter int CNT_W  = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_value,
    input  logic [REG_W-1:0]  in_reg,
    input  logic              in_is_load,
    input  logic              in_is_mwr,
    input  logic              in_is_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_W-1:0]  wb_reg,
    output logic [DATA_W-1:0] wb_data
`ifdef MEM_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  load_cnt,
    output logic [CNT_W-1:0]  store_cnt
`endif
);

    typedef struct packed {
        logic [REG_W-1:0]  dst_reg;
        logic [DATA_W-1:0] data;
    } out_rec_t;

    logic              accept;
    logic [DATA_W-1:0] ram_rdata;
    out_rec_t          out_rec;
    logic              out_is_load;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // The RAM only moves on accepted requests, so its read register stays put while a record is held.
    mem_unit_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .en   (accept),
        .we   (accept && in_is_mwr),
        .addr (in_addr),
        .wdata(in_value),
        .rdata(ram_rdata)
    );

    // Output record register: load on a writeback accept, otherwise clear valid once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_rec     <= '0;
            out_is_load <= 1'b0;
        end else if (accept && in_is_write) begin
            out_valid       <= 1'b1;
            out_rec.dst_reg <= in_reg;
            out_rec.data    <= in_value;
            out_is_load     <= in_is_load;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Load data comes straight from the RAM read register; it is never consulted after reset
    // until a new load record is captured, so reset still yields wb_data = 0.
    assign wb_reg  = out_rec.dst_reg;
    assign wb_data = out_is_load ? ram_rdata : out_rec.data;

`ifdef MEM_STAGE_STATS_EN
    // Saturating counters of accepted loads and stores; a combined request bumps both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt  <= '0;
            store_cnt <= '0;
        end else if (accept) begin
            if (in_is_load && (load_cnt != '1)) begin
                load_cnt <= load_cnt + CNT_W'(1);
            end
            if (in_is_mwr && (store_cnt != '1)) begin
                store_cnt <= store_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit. Expected writeback records are pushed onto a
// scoreboard queue when requests are driven and popped as the stage presents them.
// Counter checks run only when MEM_STAGE_STATS_EN is defined (counters built with CNT_W=2).
module tb_mem_stage_unit;
    import mem_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [15:0] in_value;
    logic [2:0]  in_reg;
    logic        in_is_load;
    logic        in_is_mwr;
    logic        in_is_write;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
`ifdef MEM_STAGE_STATS_EN
    logic [1:0]  load_cnt;
    logic [1:0]  store_cnt;
`endif

    int          checks;
    int          passes;
    wb_rec_t     exp_q [$];
    wb_rec_t     exp_rec;
    logic [15:0] model_mem [32];

    mem_stage_unit #(
        .ADDR_W(5),
        .DATA_W(16),
        .REG_W (3)
`ifdef MEM_STAGE_STATS_EN
        ,
        .CNT_W (2)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_value   (in_value),
        .in_reg     (in_reg),
        .in_is_load (in_is_load),
        .in_is_mwr  (in_is_mwr),
        .in_is_write(in_is_write),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data)
`ifdef MEM_STAGE_STATS_EN
        ,
        .load_cnt   (load_cnt),
        .store_cnt  (store_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request; when it is expected to be accepted, update the scoreboard and memory model.
    task automatic drive(input logic v, input logic [4:0] a, input logic [15:0] val,
                         input logic [2:0] r, input logic ld, input logic mwr,
                         input logic wr, input logic will_accept);
        in_valid    = v;
        in_addr     = a;
        in_value    = val;
        in_reg      = r;
        in_is_load  = ld;
        in_is_mwr   = mwr;
        in_is_write = wr;
        if (v && will_accept) begin
            if (wr) begin
                exp_q.push_back('{dst_reg: r, data: (ld ? model_mem[a] : val)});
            end
            if (mwr) begin
                model_mem[a] = val;
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", out_valid);
        else passes++;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", in_ready);
        else passes++;
        drive(1'b1, 5'd0, 16'h7777, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        idle();
        checks++;
        if (out_valid !== 1'b1 || wb_reg !== 3'd5 || wb_data !== 16'h7777)
            $display("[TB] FAIL pre_reset_record: got v=%b reg=%0d data=%h want v=1 reg=5 data=7777",
                     out_valid, wb_reg, wb_data);
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL async_reset_valid: got %b want 0", out_valid);
        else passes++;
        checks++;
        if (wb_reg !== 3'd0 || wb_data !== 16'h0)
            $display("[TB] FAIL async_reset_record: got reg=%0d data=%h want reg=0 data=0000", wb_reg, wb_data);
        else passes++;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL async_reset_ready: got %b want 1", in_ready);
        else passes++;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_store_load();
        drive(1'b1, 5'd5, 16'hABCD, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL store_no_record: got valid=%b want 0", out_valid);
        else passes++;
        drive(1'b1, 5'd5, 16'h0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL load_after_store: scoreboard empty");
        else begin
            exp_rec = exp_q.pop_front();
            if (out_valid !== 1'b1 || wb_reg !== exp_rec.dst_reg || wb_data !== exp_rec.data)
                $display("[TB] FAIL load_after_store: got v=%b reg=%0d data=%h want v=1 reg=%0d data=%h",
                         out_valid, wb_reg, wb_data, exp_rec.dst_reg, exp_rec.data);
            else passes++;
        end
        idle();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL drain_to_idle: got valid=%b want 0", out_valid);
        else passes++;
    endtask

    task automatic test_passthrough();
        drive(1'b1, 5'd2, 16'h5A5A, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b1, 5'd2, 16'h1234, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL passthrough: scoreboard empty");
        else begin
            exp_rec = exp_q.pop_front();
            if (out_valid !== 1'b1 || wb_reg !== exp_rec.dst_reg || wb_data !== exp_rec.data)
                $display("[TB] FAIL passthrough: got v=%b reg=%0d data=%h want v=1 reg=%0d data=%h",
                         out_valid, wb_reg, wb_data, exp_rec.dst_reg, exp_rec.data);
            else passes++;
        end
        drive(1'b1, 5'd2, 16'h0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL passthrough_mem_unchanged: scoreboard empty");
        else begin
            exp_rec = exp_q.pop_front();
            if (out_valid !== 1'b1 || wb_reg !== exp_rec.dst_reg || wb_data !== exp_rec.data)
                $display("[TB] FAIL passthrough_mem_unchanged: got v=%b reg=%0d data=%h want v=1 reg=%0d data=%h",
                         out_valid, wb_reg, wb_data, exp_rec.dst_reg, exp_rec.data);
            else passes++;
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_read_modify_write();
        drive(1'b1, 5'd10, 16'h00AA, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b1, 5'd10, 16'h00BB, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL rmw_old_value: scoreboard empty");
        else begin
            exp_rec = exp_q.pop_front();
            if (out_valid !== 1'b1 || wb_reg !== exp_rec.dst_reg || wb_data !== exp_rec.data)
                $display("[TB] FAIL rmw_old_value: got v=%b reg=%0d data=%h want v=1 reg=%0d data=%h",
                         out_valid, wb_reg, wb_data, exp_rec.dst_reg, exp_rec.data);
            else passes++;
        end
        drive(1'b1, 5'd10, 16'h0, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL rmw_new_value: scoreboard empty");
        else begin
            exp_rec = exp_q.pop_front();
            if (out_valid !== 1'b1 || wb_reg !== exp_rec.dst_reg || wb_data !== exp_rec.data)
                $display("[TB] FAIL rmw_new_value: got v=%b reg=%0d data=%h want v=1 reg=%0d data=%h",
                         out_valid, wb_reg, wb_data, exp_rec.dst_reg, exp_rec.data);
            else passes++;
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        drive(1'b1, 5'd9, 16'h0909, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 5'd7, 16'h1111, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b1, 5'd9, 16'hBEEF, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                wb_reg !== exp_q[0].dst_reg || wb_data !== exp_q[0].data)
                $display("[TB] FAIL hold_%0d: got rdy=%b v=%b reg=%0d data=%h want rdy=0 v=1 reg=%0d data=%h",
                         i, in_ready, out_valid, wb_reg, wb_data, exp_q[0].dst_reg, exp_q[0].data);
            else passes++;
        end
        idle();
        out_ready = 1'b1;
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL hold_release: scoreboard empty");
        else begin
            exp_rec = exp_q.pop_front();
            if (out_valid !== 1'b1 || wb_reg !== exp_rec.dst_reg || wb_data !== exp_rec.data)
                $display("[TB] FAIL hold_release: got v=%b reg=%0d data=%h want v=1 reg=%0d data=%h",
                         out_valid, wb_reg, wb_data, exp_rec.dst_reg, exp_rec.data);
            else passes++;
        end
        @(negedge clk);
        drive(1'b1, 5'd9, 16'h0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL held_store_dropped: scoreboard empty");
        else begin
            exp_rec = exp_q.pop_front();
            if (out_valid !== 1'b1 || wb_reg !== exp_rec.dst_reg || wb_data !== exp_rec.data)
                $display("[TB] FAIL held_store_dropped: got v=%b reg=%0d data=%h want v=1 reg=%0d data=%h",
                         out_valid, wb_reg, wb_data, exp_rec.dst_reg, exp_rec.data);
            else passes++;
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(i), 16'h1000 + 16'(i * 16'h0111), 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
            @(negedge clk);
        end
        drive(1'b1, 5'd0, 16'h0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) $display("[TB] FAIL stream_%0d: scoreboard empty", i);
            else begin
                exp_rec = exp_q.pop_front();
                if (out_valid !== 1'b1 || in_ready !== 1'b1 ||
                    wb_reg !== exp_rec.dst_reg || wb_data !== exp_rec.data)
                    $display("[TB] FAIL stream_%0d: got v=%b rdy=%b reg=%0d data=%h want v=1 rdy=1 reg=%0d data=%h",
                             i, out_valid, in_ready, wb_reg, wb_data, exp_rec.dst_reg, exp_rec.data);
                else passes++;
            end
            if (i < 3) drive(1'b1, 5'(i + 1), 16'h0, 3'(i + 1), 1'b1, 1'b0, 1'b1, 1'b1);
            else idle();
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL stream_end_idle: got valid=%b want 0", out_valid);
        else passes++;
    endtask

`ifdef MEM_STAGE_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        checks++;
        if (load_cnt !== 2'd0 || store_cnt !== 2'd0)
            $display("[TB] FAIL stats_reset: got ld=%0d st=%0d want ld=0 st=0", load_cnt, store_cnt);
        else passes++;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'(20 + i), 16'(16'h0200 + i), 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
            @(negedge clk);
        end
        idle();
        checks++;
        if (load_cnt !== 2'd0 || store_cnt !== 2'd3)
            $display("[TB] FAIL stats_store_sat: got ld=%0d st=%0d want ld=0 st=3", load_cnt, store_cnt);
        else passes++;
        drive(1'b1, 5'd20, 16'h0055, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        idle();
        checks++;
        if (load_cnt !== 2'd1 || store_cnt !== 2'd3)
            $display("[TB] FAIL stats_load_and_store: got ld=%0d st=%0d want ld=1 st=3", load_cnt, store_cnt);
        else passes++;
        @(negedge clk);
    endtask
`endif

    // Run every scenario in order, then report the totals.
    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_store_load();
        test_passthrough();
        test_read_modify_write();
        test_back_pressure();
        test_back_to_back();
`ifdef MEM_STAGE_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
